truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Synthesizable stimulus/capture stage for 3-input combinational lab circuits.
//  Sits upstream of the DUT: it drives {A,B,C} through all 2**N_IN input combinations.
//  Sits downstream of the DUT too: it samples Y on each combination and builds the captured truth table.
//  Compares the captured table against an expected table and reports pass/fail, error count and first failing index.
// PARAMETERS
//  N_IN    3   number of DUT inputs; table width TW = 2**N_IN
//  SETTLE  2   cycles each vector is held before Y is sampled; legal range >=1
// PORTS
//  clk          in   1        single clock; all state updates on rising edge
//  rst          in   1        synchronous, active-high reset
//  start        in   1        sweep request; honoured only in IDLE
//  exp_table    in   TW       expected Y per index; bit i = Y for abc==i; latched on accepted start
//  y_in         in   1        DUT output Y
//  abc          out  N_IN     DUT input vector; bit N_IN-1 = A, bit 0 = C
//  busy         out  1        high from the cycle after start acceptance until DONE inclusive
//  done         out  1        one-cycle pulse at sweep end
//  pass         out  1        1 when err_count==0; valid from done, held until next accepted start
//  captured     out  TW       sampled Y per index
//  err_count    out  N_IN+1   number of mismatching indices, 0..TW
//  first_err    out  N_IN     lowest mismatching index; 0 when pass=1
// BEHAVIOUR
//  Reset values: state=IDLE, abc=0, busy=0, done=0, pass=0, captured=0, err_count=0, first_err=0, idx=0, settle_cnt=0.
//  FSM states: IDLE, SETTLE, SAMPLE, DONE.
//  - IDLE: on start=1, latch exp_table, clear captured, err_count and first_err, set idx=0 and settle_cnt=0, then go to SETTLE.
//  - SETTLE: abc=idx; settle_cnt++ each cycle; after SETTLE cycles in this state, go to SAMPLE.
//  - SAMPLE: abc still = idx (never changes in the sampling cycle). Actions this cycle:
//      captured[idx] <= y_in.
//      If y_in != exp[idx]: err_count++; if this is the first mismatch, first_err <= idx.
//      If idx == TW-1: go to DONE. Otherwise idx++, settle_cnt=0, go to SETTLE.
//  - DONE: done=1 for exactly this cycle; pass <= (final err_count==0); abc <= 0; go to IDLE.
//  Timing:
//  - Each vector occupies SETTLE+1 cycles.
//  - If start is sampled at cycle 0, done is high at cycle TW*(SETTLE+1)+1. With the defaults this is cycle 25.
//  - The first mismatch in index order wins first_err; later mismatches only increment err_count.
//  - err_count saturates naturally at TW and never wraps; its width is N_IN+1.
//  - abc is 0 in IDLE and after DONE; the DUT only ever sees indices 0..TW-1, in ascending order.
//  Boundary conditions:
//  - start while busy: ignored; no restart and no second done.
//  - start held high continuously: a new sweep begins on the IDLE cycle following DONE.
//  - rst during any state: next cycle is IDLE with all reset values; a partial table is discarded and done is not pulsed.
//  - rst and start in the same cycle: rst wins.
//  - exp_table changes mid-sweep: no effect; only the value latched at start is used.
// TESTING
//  1 y_in = ^abc (XOR DUT), exp=8'h96, start at cycle 0 -> done at cycle 25; captured=8'h96, err_count=0, pass=1, first_err=0.
//  2 y_in = majority(A,B,C), exp=8'hE9 -> captured=8'hE8, err_count=1, first_err=0, pass=0.
//  3 y_in = 0, exp=8'hF0 -> err_count=4, first_err=4, captured=8'h00, pass=0.
//  4 check abc trace: 0 on cycles 1-3, 1 on cycles 4-6, ..., 7 on cycles 22-24, 0 at cycle 25; busy high on cycles 1-25.
//  5 pulse start again at cycle 10 -> ignored; single done at cycle 25; results same as scenario 1.
//  6 rst at cycle 12 -> cycle 13: IDLE, abc=0, busy=0, captured=0, err_count=0; new start at cycle 15 -> done at cycle 40.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: steps a 3-input DUT through every input vector,
// captures Y for each vector and scores it against an expected table.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start        sweep request, honoured only while idle
//   exp_table    expected Y per index, latched when a sweep is accepted
//   y_in         DUT output Y
//   abc          DUT input vector (A = MSB, C = LSB), 0 when not sweeping
//   busy, done   sweep in progress / one-cycle end-of-sweep pulse
//   pass         no mismatches; valid from done until the next sweep
//   captured     sampled Y per index
//   err_count    number of mismatching indices
//   first_err    lowest mismatching index, 0 when pass
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   exp_table,
    input  logic                 y_in,
    output logic [N_IN-1:0]      abc,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   captured,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err
);

    localparam int TW  = 2**N_IN;
    localparam int SCW = $clog2(SETTLE + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [SCW-1:0]  settle_q, settle_d;
    logic [TW-1:0]   exp_q, exp_d;
    logic [TW-1:0]   cap_q, cap_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ferr_q, ferr_d;
    logic            pass_q, pass_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        exp_d    = exp_q;
        cap_d    = cap_q;
        err_d    = err_q;
        ferr_d   = ferr_q;
        pass_d   = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    exp_d    = exp_table;
                    cap_d    = '0;
                    err_d    = '0;
                    ferr_d   = '0;
                    pass_d   = 1'b0;
                    idx_d    = '0;
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                settle_d = settle_q + SCW'(1);
                if (settle_q == SCW'(SETTLE - 1)) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                cap_d[idx_q] = y_in;
                if (y_in != exp_q[idx_q]) begin
                    err_d = err_q + (N_IN+1)'(1);
                    // err_q still zero means this is the first mismatch
                    if (err_q == '0) begin
                        ferr_d = idx_q;
                    end
                end
                if (idx_q == N_IN'(TW - 1)) begin
                    // Resolve pass now so it is already valid alongside done
                    pass_d  = (err_d == '0);
                    state_d = S_DONE;
                end else begin
                    idx_d    = idx_q + N_IN'(1);
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end
            end
            S_DONE: begin
                pass_d  = (err_q == '0);
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            exp_q    <= '0;
            cap_q    <= '0;
            err_q    <= '0;
            ferr_q   <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            exp_q    <= exp_d;
            cap_q    <= cap_d;
            err_q    <= err_d;
            ferr_q   <= ferr_d;
            pass_q   <= pass_d;
        end
    end

    // The vector is only presented while settling/sampling; 0 otherwise
    assign abc = (state_q == S_SETTLE || state_q == S_SAMPLE) ? idx_q : '0;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign captured  = cap_q;
    assign err_count = err_q;
    assign first_err = ferr_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: per-scenario tasks with a queue of
// model-computed sweep results compared when the DUT signals done.
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] exp_table;
    logic       y_in;
    logic [2:0] abc;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] captured;
    logic [3:0] err_count;
    logic [2:0] first_err;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    truth_table_sweeper dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .exp_table (exp_table),
        .y_in      (y_in),
        .abc       (abc),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .captured  (captured),
        .err_count (err_count),
        .first_err (first_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lab circuit under test: 0 = XOR, 1 = majority, 2 = constant 0
    always_comb begin
        y_in = 1'b0;
        if (mode == 0) y_in = ^abc;
        else if (mode == 1) y_in = (abc[2] & abc[1]) | (abc[2] & abc[0]) | (abc[1] & abc[0]);
    end

    typedef struct {
        logic [7:0] cap;
        logic [3:0] err;
        logic [2:0] ferr;
        logic       pass;
        int         done_cyc;
    } res_t;

    res_t exp_q[$];

    function automatic res_t model(input int fn, input logic [7:0] ex, input int start_cyc);
        res_t r;
        logic a, b, c, y;
        r.cap = '0;
        r.err = '0;
        r.ferr = '0;
        for (int i = 0; i < 8; i++) begin
            a = (i >> 2) & 1;
            b = (i >> 1) & 1;
            c = i & 1;
            if (fn == 0) y = a ^ b ^ c;
            else if (fn == 1) y = (a & b) | (a & c) | (b & c);
            else y = 1'b0;
            r.cap[i] = y;
            if (y != ex[i]) begin
                if (r.err == 0) r.ferr = 3'(i);
                r.err = r.err + 1;
            end
        end
        r.pass = (r.err == 0);
        r.done_cyc = start_cyc + 8 * 3 + 1;
        return r;
    endfunction

    logic [2:0] abc_tr  [0:127];
    logic       busy_tr [0:127];
    logic       done_tr [0:127];
    logic [7:0] cap_tr  [0:127];
    logic [3:0] err_tr  [0:127];
    int         first_done;
    int         done_cnt;
    logic [7:0] s_cap;
    logic [3:0] s_err;
    logic [2:0] s_ferr;
    logic       s_pass;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives start in cycle 0, then records ncyc cycles of outputs.
    // Optional extra start pulse, reset pulse, held start and exp change.
    task automatic run_sweep(input int ncyc, input int restart_at,
                             input int rst_at, input bit hold,
                             input int chg_at, input logic [7:0] chg_val);
        start = 1'b1;
        step();
        start = hold;
        first_done = -1;
        done_cnt = 0;
        for (int c = 1; c <= ncyc; c++) begin
            abc_tr[c]  = abc;
            busy_tr[c] = busy;
            done_tr[c] = done;
            cap_tr[c]  = captured;
            err_tr[c]  = err_count;
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = c;
                    s_cap  = captured;
                    s_err  = err_count;
                    s_ferr = first_err;
                    s_pass = pass;
                end
            end
            start = hold || (c == restart_at);
            rst   = (c == rst_at);
            if (c == chg_at) exp_table = chg_val;
            step();
        end
        start = 1'b0;
        rst   = 1'b0;
        for (int k = 0; k < 60 && busy === 1'b1; k++) step();
        step();
    endtask

    task automatic compare_sweep(input string name);
        res_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no expected entry queued", name);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (first_done !== e.done_cyc) begin
            errors++;
            $display("FAIL %s done_cyc: got %0d want %0d", name, first_done, e.done_cyc);
        end
        checks++;
        if (s_cap !== e.cap) begin
            errors++;
            $display("FAIL %s captured: got %h want %h", name, s_cap, e.cap);
        end
        checks++;
        if (s_err !== e.err) begin
            errors++;
            $display("FAIL %s err_count: got %0d want %0d", name, s_err, e.err);
        end
        checks++;
        if (s_ferr !== e.ferr) begin
            errors++;
            $display("FAIL %s first_err: got %0d want %0d", name, s_ferr, e.ferr);
        end
        checks++;
        if (s_pass !== e.pass) begin
            errors++;
            $display("FAIL %s pass: got %b want %b", name, s_pass, e.pass);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        step();
        step();
        rst = 1'b0;
        start = 1'b0;
        checks++;
        if ({abc, busy, done, pass, captured, err_count, first_err} !== 20'd0) begin
            errors++;
            $display("FAIL reset: got abc=%0d busy=%b done=%b pass=%b cap=%h err=%0d ferr=%0d want all 0",
                     abc, busy, done, pass, captured, err_count, first_err);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_same: busy got %b want 0", busy);
        end
    endtask

    task automatic test_xor();
        mode = 0;
        exp_table = 8'h96;
        exp_q.push_back(model(0, 8'h96, 0));
        run_sweep(30, -1, -1, 0, -1, 8'h00);
        compare_sweep("xor");
    endtask

    task automatic test_majority();
        mode = 1;
        exp_table = 8'hE9;
        exp_q.push_back(model(1, 8'hE9, 0));
        run_sweep(30, -1, -1, 0, -1, 8'h00);
        compare_sweep("majority");
    endtask

    task automatic test_zero();
        mode = 2;
        exp_table = 8'hF0;
        exp_q.push_back(model(2, 8'hF0, 0));
        run_sweep(30, -1, -1, 0, -1, 8'h00);
        compare_sweep("zero");
    endtask

    task automatic test_trace();
        int bad_abc;
        int bad_busy;
        mode = 0;
        exp_table = 8'h96;
        exp_q.push_back(model(0, 8'h96, 0));
        run_sweep(30, -1, -1, 0, -1, 8'h00);
        compare_sweep("trace");
        bad_abc = 0;
        bad_busy = 0;
        for (int c = 1; c <= 25; c++) begin
            if (abc_tr[c] !== ((c <= 24) ? 3'((c - 1) / 3) : 3'd0)) bad_abc++;
            if (busy_tr[c] !== 1'b1) bad_busy++;
        end
        checks++;
        if (bad_abc != 0) begin
            errors++;
            $display("FAIL trace_abc: got %0d bad cycles want 0", bad_abc);
        end
        checks++;
        if (bad_busy != 0) begin
            errors++;
            $display("FAIL trace_busy: got %0d bad cycles want 0", bad_busy);
        end
        checks++;
        if (busy_tr[26] !== 1'b0 || abc_tr[26] !== 3'd0) begin
            errors++;
            $display("FAIL trace_idle: busy=%b abc=%0d at 26 want 0 0", busy_tr[26], abc_tr[26]);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL trace_done_cnt: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_start_busy();
        mode = 0;
        exp_table = 8'h96;
        exp_q.push_back(model(0, 8'h96, 0));
        run_sweep(40, 10, -1, 0, -1, 8'h00);
        compare_sweep("start_busy");
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL start_busy_done_cnt: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_exp_change();
        mode = 1;
        exp_table = 8'hE8;
        exp_q.push_back(model(1, 8'hE8, 0));
        run_sweep(30, -1, -1, 0, 5, 8'h17);
        compare_sweep("exp_change");
    endtask

    task automatic test_mid_reset();
        mode = 0;
        exp_table = 8'h96;
        exp_q.push_back(model(0, 8'h96, 15));
        run_sweep(45, 15, 12, 0, -1, 8'h00);
        compare_sweep("mid_reset");
        checks++;
        if (busy_tr[13] !== 1'b0 || abc_tr[13] !== 3'd0 ||
            cap_tr[13] !== 8'h00 || err_tr[13] !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_idle: busy=%b abc=%0d cap=%h err=%0d want 0 0 00 0",
                     busy_tr[13], abc_tr[13], cap_tr[13], err_tr[13]);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL mid_reset_done_cnt: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        mode = 2;
        exp_table = 8'h00;
        exp_q.push_back(model(2, 8'h00, 0));
        run_sweep(55, -1, -1, 1, -1, 8'h00);
        compare_sweep("back_to_back");
        checks++;
        if (done_tr[51] !== 1'b1 || done_cnt !== 2) begin
            errors++;
            $display("FAIL back_to_back_second: done@51=%b count=%0d want 1 2", done_tr[51], done_cnt);
        end
        checks++;
        if (busy_tr[26] !== 1'b0 || busy_tr[27] !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_gap: busy26=%b busy27=%b want 0 1", busy_tr[26], busy_tr[27]);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        exp_table = 8'h00;
        step();
        test_reset();
        test_xor();
        test_majority();
        test_zero();
        test_trace();
        test_start_busy();
        test_exp_change();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
